// File: rtl/pipe_pkg.sv
// Shared types and defaults for elastic pipeline stages.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } pipe_state_e;

  localparam int PIPE_DATA_W_DEFAULT = 64;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones, cleared only by async reset.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    if (&v) return v;
    return v + {{(W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    count <= '0;
    else if (inc) count <= sat_inc(count);
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register with one-entry skid buffer, registered ready and flush.
// Optional perf counters enabled by defining PIPE_STAGE_PERF_EN.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                 DATA_W     = PIPE_DATA_W_DEFAULT,
  parameter logic [DATA_W-1:0]  RESET_DATA = '0,
  parameter int                 CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  bubble_cycles
);

  pipe_state_e       state_p1, state_d;
  logic [DATA_W-1:0] main_p1, main_d;
  logic [DATA_W-1:0] skid_p1, skid_d;
  logic              rdy_p1;
  logic              in_xfer, out_xfer;

  assign in_xfer  = in_valid & rdy_p1;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_d = state_p1;
    main_d  = main_p1;
    skid_d  = skid_p1;
    case (state_p1)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = in_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        case ({in_xfer, out_xfer})
          2'b11: main_d = in_data;
          2'b10: begin
            skid_d  = in_data;
            state_d = FULL;
          end
          2'b01: begin
            main_d  = RESET_DATA;
            state_d = EMPTY;
          end
          default: ;
        endcase
      end
      FULL: begin
        if (out_xfer) begin
          main_d  = skid_p1;
          skid_d  = RESET_DATA;
          state_d = BUSY;
        end
      end
      default: begin
        main_d  = RESET_DATA;
        skid_d  = RESET_DATA;
        state_d = EMPTY;
      end
    endcase
    // Squash wins over everything; an accepted input this cycle is dropped.
    if (flush) begin
      main_d  = RESET_DATA;
      skid_d  = RESET_DATA;
      state_d = EMPTY;
    end
  end

  // Stage p1: state, main/skid payload and registered ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p1 <= EMPTY;
      main_p1  <= RESET_DATA;
      skid_p1  <= RESET_DATA;
      rdy_p1   <= 1'b1;
    end else begin
      state_p1 <= state_d;
      main_p1  <= main_d;
      skid_p1  <= skid_d;
      rdy_p1   <= (state_d != FULL);
    end
  end

  assign in_ready  = rdy_p1;
  assign out_valid = (state_p1 != EMPTY);
  assign out_data  = main_p1;

`ifdef PIPE_STAGE_PERF_EN
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid & ~out_ready),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~out_valid),
    .count (bubble_cycles)
  );
`else
  assign stall_cycles  = '0;
  assign bubble_cycles = '0;
`endif

endmodule
